// File: rtl/elc_keypad_tx_if.sv
// Pin-side and lock-side signals of the keypad/card front end.
// master = the board/keypad side driving raw pins, slave = the front end itself.
interface elc_keypad_tx_if;
  logic [7:0] key_raw;
  logic       enter_raw;
  logic       card_raw;
  logic [2:0] in;
  logic       enter;
  logic       card_is_in;
  logic       digit_valid;
  logic       key_error;

  modport master (
    output key_raw, enter_raw, card_raw,
    input  in, enter, card_is_in, digit_valid, key_error
  );

  modport slave (
    input  key_raw, enter_raw, card_raw,
    output in, enter, card_is_in, digit_valid, key_error
  );
endinterface

// File: rtl/elc_keypad_tx.sv
// Keypad/card front end for the lock controller: synchronises and debounces raw keys
// and the card sensor; accepted patterns become a held digit, an enter pulse or an error pulse.
module elc_keypad_tx #(
  parameter int unsigned DEBOUNCE     = 4,
  parameter int unsigned IDLE_TIMEOUT = 20
) (
  input  logic           clk,
  input  logic           reset,
  elc_keypad_tx_if.slave kp
);

  localparam logic [5:0] DEB_LIM = 6'(DEBOUNCE);
  localparam logic [7:0] TMO_LIM = 8'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {
    KEY_IDLE,
    KEY_DEB,
    KEY_HELD,
    KEY_REL
  } key_state_e;

  logic [8:0] p_meta_q, p_meta_d;
  logic [8:0] p_sync_q, p_sync_d;
  logic       card_meta_q, card_meta_d;
  logic       card_sync_q, card_sync_d;

  key_state_e state_q, state_d;
  logic [8:0] pat_q, pat_d;
  logic [5:0] cnt_q, cnt_d;
  logic       accept;

  logic [2:0] dig_idx;
  logic       is_digit;
  logic       is_enter_only;

  logic [7:0] tmo_q, tmo_d;
  logic [7:0] tmo_inc;
  logic [2:0] in_q, in_d;
  logic       dv_q, dv_d;
  logic       enter_q, enter_d;
  logic       kerr_q, kerr_d;

  logic       card_q, card_d;
  logic [5:0] ccnt_q, ccnt_d;

  // Two-flop synchronisers for the keypad pattern and the card sensor.
  always_comb begin
    p_meta_d    = {kp.enter_raw, kp.key_raw};
    p_sync_d    = p_meta_q;
    card_meta_d = kp.card_raw;
    card_sync_d = card_meta_q;
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      KEY_IDLE: begin
        if (p_sync_q != 9'd0) begin
          pat_d = p_sync_q;
          cnt_d = 6'd1;
          if (cnt_d == DEB_LIM) begin
            accept  = 1'b1;
            state_d = KEY_HELD;
          end else begin
            state_d = KEY_DEB;
          end
        end
      end
      KEY_DEB: begin
        if (p_sync_q == 9'd0) begin
          cnt_d   = 6'd0;
          state_d = KEY_IDLE;
        end else begin
          // A bounce to a different non-zero pattern restarts the count on that pattern.
          if (p_sync_q != pat_q) begin
            pat_d = p_sync_q;
            cnt_d = 6'd1;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
          if (cnt_d == DEB_LIM) begin
            accept  = 1'b1;
            state_d = KEY_HELD;
          end
        end
      end
      KEY_HELD: begin
        if (p_sync_q == 9'd0) begin
          cnt_d   = 6'd1;
          state_d = (cnt_d == DEB_LIM) ? KEY_IDLE : KEY_REL;
        end
      end
      KEY_REL: begin
        if (p_sync_q != 9'd0) begin
          state_d = KEY_HELD;
        end else begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_d == DEB_LIM) begin
            state_d = KEY_IDLE;
          end
        end
      end
      default: begin
        state_d = KEY_IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  always_comb begin
    dig_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pat_d[i]) begin
        dig_idx = 3'(i);
      end
    end
    is_digit      = !pat_d[8] && $onehot(pat_d[7:0]);
    is_enter_only = pat_d[8] && (pat_d[7:0] == 8'd0);
  end

  // Accept actions, timeout and post-enter clear; an enter accept overrides a same-edge timeout.
  always_comb begin
    in_d    = in_q;
    dv_d    = dv_q;
    enter_d = 1'b0;
    kerr_d  = 1'b0;
    tmo_d   = tmo_q;
    tmo_inc = tmo_q + 8'd1;
    if (enter_q) begin
      in_d  = 3'd0;
      dv_d  = 1'b0;
      tmo_d = 8'd0;
    end else if (dv_q) begin
      tmo_d = tmo_inc;
      if (tmo_inc == TMO_LIM) begin
        in_d  = 3'd0;
        dv_d  = 1'b0;
        tmo_d = 8'd0;
      end
    end
    if (accept) begin
      if (is_digit) begin
        in_d  = dig_idx;
        dv_d  = 1'b1;
        tmo_d = 8'd0;
      end else if (is_enter_only && dv_q) begin
        enter_d = 1'b1;
        in_d    = in_q;
        dv_d    = 1'b1;
      end else begin
        kerr_d = 1'b1;
      end
    end
  end

  always_comb begin
    card_d = card_q;
    ccnt_d = 6'd0;
    if (card_sync_q != card_q) begin
      ccnt_d = ccnt_q + 6'd1;
      if (ccnt_d == DEB_LIM) begin
        card_d = ~card_q;
        ccnt_d = 6'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_meta_q    <= 9'd0;
      p_sync_q    <= 9'd0;
      card_meta_q <= 1'b0;
      card_sync_q <= 1'b0;
      state_q     <= KEY_IDLE;
      pat_q       <= 9'd0;
      cnt_q       <= 6'd0;
      tmo_q       <= 8'd0;
      in_q        <= 3'd0;
      dv_q        <= 1'b0;
      enter_q     <= 1'b0;
      kerr_q      <= 1'b0;
      card_q      <= 1'b0;
      ccnt_q      <= 6'd0;
    end else begin
      p_meta_q    <= p_meta_d;
      p_sync_q    <= p_sync_d;
      card_meta_q <= card_meta_d;
      card_sync_q <= card_sync_d;
      state_q     <= state_d;
      pat_q       <= pat_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      in_q        <= in_d;
      dv_q        <= dv_d;
      enter_q     <= enter_d;
      kerr_q      <= kerr_d;
      card_q      <= card_d;
      ccnt_q      <= ccnt_d;
    end
  end

  assign kp.in          = in_q;
  assign kp.enter       = enter_q;
  assign kp.card_is_in  = card_q;
  assign kp.digit_valid = dv_q;
  assign kp.key_error   = kerr_q;

endmodule

// File: tb/tb_elc_keypad_tx.sv
// Randomised scoreboard bench for elc_keypad_tx: presses and card segments predict
// time-stamped events, a negedge monitor matches every observed output change.
module tb_elc_keypad_tx;
  localparam int DEB = 4;
  localparam int TMO = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  elc_keypad_tx_if kp_if();

  elc_keypad_tx #(.DEBOUNCE(DEB), .IDLE_TIMEOUT(TMO)) dut (
    .clk  (clk),
    .reset(reset),
    .kp   (kp_if)
  );

  typedef struct {
    int cyc;
    int kind;  // pulses: 0 enter, 1 key_error
    int val;
  } ev_t;

  ev_t key_q[$];
  ev_t dv_q[$];
  ev_t card_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pulses_seen = 0;
  bit mon_en = 1'b0;

  // Reference state: what the lock side should currently believe.
  bit dv_m = 1'b0;
  int in_m = 0;
  int tmo_at = 0;
  bit tmo_pend = 1'b0;
  bit card_m = 1'b0;
  bit card_lvl = 1'b0;

  logic [2:0] p_in;
  logic p_dv, p_card, p_enter, p_kerr;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk(int c, int k, int v);
    ev_t e;
    e.cyc = c;
    e.kind = k;
    e.val = v;
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic report_missing(string name, ev_t e);
    tests++;
    fails++;
    $display("FAIL missing_%s: expected at cycle %0d value %0d, nothing seen by cycle %0d",
             name, e.cyc, e.val, cyc);
  endtask

  task automatic report_unexpected(string name, int v);
    tests++;
    fails++;
    $display("FAIL unexpected_%s at cycle %0d: got value %0d, expected no event", name, cyc, v);
  endtask

  // Key rules: digit loads and restarts the idle timer, enter submits a pending digit,
  // everything else is an error; the timer expiring TMO edges after a digit clears it.
  task automatic model_accept(int t, logic [8:0] pat);
    bit digit, enter_only;
    int idx;
    digit = !pat[8] && ($countones(pat[7:0]) == 1);
    enter_only = pat[8] && (pat[7:0] == 8'd0);
    idx = 0;
    for (int i = 0; i < 8; i++) if (pat[i]) idx = i;
    if (dv_m && tmo_at < t) begin
      dv_m = 1'b0; in_m = 0; tmo_pend = 1'b0;
    end else if (dv_m && tmo_at == t && !digit && !enter_only) begin
      dv_m = 1'b0; in_m = 0; tmo_pend = 1'b0;
    end else if (dv_m && (digit || enter_only)) begin
      if (tmo_pend) void'(dv_q.pop_back());
      tmo_pend = 1'b0;
    end
    if (digit) begin
      if (!(dv_m && in_m == idx)) dv_q.push_back(mk(t, 0, 8 + idx));
      dv_m = 1'b1;
      in_m = idx;
      tmo_at = t + TMO;
      dv_q.push_back(mk(tmo_at, 0, 0));
      tmo_pend = 1'b1;
    end else if (enter_only && dv_m) begin
      key_q.push_back(mk(t, 0, in_m));
      dv_q.push_back(mk(t + 1, 0, 0));
      dv_m = 1'b0;
      in_m = 0;
    end else begin
      key_q.push_back(mk(t, 1, 0));
    end
  endtask

  // A pattern is accepted DEB+2 edges after it starts if it stays unchanged for DEB samples.
  task automatic press(logic [8:0] pat, int hold, int gap, logic [8:0] pre, int pre_len);
    int k;
    if (pre_len > 0) begin
      @(posedge clk); #1;
      {kp_if.enter_raw, kp_if.key_raw} = pre;
      repeat (pre_len - 1) @(posedge clk);
    end
    @(posedge clk); #1;
    {kp_if.enter_raw, kp_if.key_raw} = pat;
    k = cyc;
    if (hold >= DEB && pat != 9'd0) model_accept(k + DEB + 2, pat);
    repeat (hold - 1) @(posedge clk);
    @(posedge clk); #1;
    {kp_if.enter_raw, kp_if.key_raw} = 9'd0;
    repeat (gap - 1) @(posedge clk);
  endtask

  // Card raw level alternates per segment; a differing segment of DEB+ cycles flips the level.
  task automatic cseg(int len);
    int k;
    @(posedge clk); #1;
    card_lvl = ~card_lvl;
    kp_if.card_raw = card_lvl;
    k = cyc;
    if (card_lvl != card_m && len >= DEB) begin
      card_q.push_back(mk(k + DEB + 2, 2, int'(card_lvl)));
      card_m = card_lvl;
    end
    repeat (len - 1) @(posedge clk);
  endtask

  task automatic monitor_step();
    ev_t e;
    logic [3:0] dvin;
    while (key_q.size() > 0 && key_q[0].cyc < cyc) begin
      e = key_q.pop_front();
      report_missing("pulse", e);
    end
    while (dv_q.size() > 0 && dv_q[0].cyc < cyc) begin
      e = dv_q.pop_front();
      report_missing("digit_state", e);
    end
    while (card_q.size() > 0 && card_q[0].cyc < cyc) begin
      e = card_q.pop_front();
      report_missing("card", e);
    end
    chk("enter_error_exclusive", 32'(kp_if.enter & kp_if.key_error), 0);
    chk("enter_single_cycle", 32'(kp_if.enter & p_enter), 0);
    chk("error_single_cycle", 32'(kp_if.key_error & p_kerr), 0);
    if (kp_if.enter || kp_if.key_error) begin
      pulses_seen++;
      if (key_q.size() == 0) begin
        report_unexpected("pulse", kp_if.enter ? 0 : 1);
      end else begin
        e = key_q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_kind", kp_if.enter ? 0 : 1, e.kind);
        if (e.kind == 0) chk("enter_in", 32'(kp_if.in), e.val);
      end
    end
    dvin = {kp_if.digit_valid, kp_if.in};
    if (dvin != {p_dv, p_in}) begin
      if (dv_q.size() == 0) begin
        report_unexpected("digit_state", int'(dvin));
      end else begin
        e = dv_q.pop_front();
        chk("digit_state_cycle", cyc, e.cyc);
        chk("digit_state_value", 32'(dvin), e.val);
      end
    end
    if (kp_if.card_is_in != p_card) begin
      if (card_q.size() == 0) begin
        report_unexpected("card", int'(kp_if.card_is_in));
      end else begin
        e = card_q.pop_front();
        chk("card_cycle", cyc, e.cyc);
        chk("card_value", 32'(kp_if.card_is_in), e.val);
      end
    end
    p_in = kp_if.in;
    p_dv = kp_if.digit_valid;
    p_card = kp_if.card_is_in;
    p_enter = kp_if.enter;
    p_kerr = kp_if.key_error;
  endtask

  always @(negedge clk) if (mon_en) monitor_step();

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] pat, pre;
    int r, hold, gap, pre_len, base, j;
    reset = 1'b0;
    kp_if.key_raw = 8'd0;
    kp_if.enter_raw = 1'b0;
    kp_if.card_raw = 1'b0;
    p_in = 3'd0; p_dv = 1'b0; p_card = 1'b0; p_enter = 1'b0; p_kerr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_in", 32'(kp_if.in), 0);
    chk("reset_enter", 32'(kp_if.enter), 0);
    chk("reset_card", 32'(kp_if.card_is_in), 0);
    chk("reset_digit_valid", 32'(kp_if.digit_valid), 0);
    chk("reset_key_error", 32'(kp_if.key_error), 0);
    #2;
    reset = 1'b1;
    mon_en = 1'b1;

    fork
      begin
        press(9'h004, 10, 8, 9'd0, 0);          // digit 2
        press(9'h100, 6, 8, 9'd0, 0);           // enter submits 2
        repeat (5) press(9'h004, 2, 2, 9'd0, 0); // bouncing key, never accepted
        repeat (6) @(posedge clk);
        #1;
        chk("toggle_digit_valid", 32'(kp_if.digit_valid), 0);
        chk("toggle_in", 32'(kp_if.in), 0);
        chk("toggle_key_error", 32'(kp_if.key_error), 0);
        press(9'h003, 8, 8, 9'd0, 0);           // two digits -> error
        press(9'h100, 6, 8, 9'd0, 0);           // enter with nothing pending -> error
        press(9'h020, 6, 30, 9'd0, 0);          // digit 5 then idle past timeout
        press(9'h100, 6, 8, 9'd0, 0);           // late enter -> error
        press(9'h008, 6, 14, 9'd0, 0);          // digit 3
        press(9'h100, 6, 8, 9'd0, 0);           // enter lands on the timeout edge
        for (int n = 0; n < 45; n++) begin
          r = $urandom_range(0, 9);
          if (r < 6) pat = 9'(1 << $urandom_range(0, 7));
          else if (r < 8) pat = 9'h100;
          else pat = 9'(1 << $urandom_range(0, 7)) | 9'(1 << $urandom_range(0, 8));
          hold = $urandom_range(1, DEB + 4);
          gap = ($urandom_range(0, 3) == 0) ? $urandom_range(DEB + 1, 30)
                                            : $urandom_range(DEB + 1, DEB + 8);
          pre = 9'd0;
          pre_len = 0;
          if ($urandom_range(0, 3) == 0) begin
            j = $urandom_range(0, 8);
            while (pat[j]) j = $urandom_range(0, 8);
            pre = pat | 9'(1 << j);
            pre_len = $urandom_range(1, DEB - 1);
          end
          press(pat, hold, gap, pre, pre_len);
        end
      end
      begin
        cseg(2);   // glitch
        cseg(6);
        cseg(10);  // card in
        for (int n = 0; n < 40; n++) cseg($urandom_range(1, 2 * DEB));
        cseg(DEB + 4);
      end
    join

    repeat (TMO + DEB + 10) @(posedge clk);
    #1;
    chk("pulse_queue_drained", key_q.size(), 0);
    chk("digit_queue_drained", dv_q.size(), 0);
    chk("card_queue_drained", card_q.size(), 0);

    if (card_lvl == 1'b0) cseg(DEB + 4);
    press(9'h040, 6, 8, 9'd0, 0);               // digit 6 pending
    @(posedge clk); #1;
    kp_if.key_raw = 8'h02;                      // mid-debounce when reset hits
    repeat (4) @(posedge clk);
    #2;
    chk("pre_reset_digit_valid", 32'(kp_if.digit_valid), 1);
    chk("pre_reset_in", 32'(kp_if.in), 6);
    chk("pre_reset_card", 32'(kp_if.card_is_in), 1);
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrun_reset_in", 32'(kp_if.in), 0);
    chk("midrun_reset_enter", 32'(kp_if.enter), 0);
    chk("midrun_reset_card", 32'(kp_if.card_is_in), 0);
    chk("midrun_reset_digit_valid", 32'(kp_if.digit_valid), 0);
    chk("midrun_reset_key_error", 32'(kp_if.key_error), 0);
    kp_if.key_raw = 8'd0;
    kp_if.card_raw = 1'b0;
    card_lvl = 1'b0; card_m = 1'b0;
    dv_m = 1'b0; in_m = 0; tmo_pend = 1'b0;
    key_q.delete(); dv_q.delete(); card_q.delete();
    repeat (3) @(negedge clk);
    #2;
    p_in = 3'd0; p_dv = 1'b0; p_card = 1'b0; p_enter = 1'b0; p_kerr = 1'b0;
    base = pulses_seen;
    reset = 1'b1;
    mon_en = 1'b1;
    repeat (DEB + TMO) @(posedge clk);
    #1;
    chk("no_pulse_after_reset", pulses_seen - base, 0);
    chk("post_reset_digit_valid", 32'(kp_if.digit_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
